// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares a single FIFO write port among NUM_REQ
// producers. One requester at a time owns the port for a burst of up to
// MAX_BURST words. Backpressure comes from the FIFO occupancy count. The FIFO
// write enable and write data are driven straight from registers.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous, active-high reset
//   req_valid     per-requester word-available flags
//   req_data      per-requester words, requester i at [i*DATA_W +: DATA_W]
//   req_ready     combinational accept strobe (valid && ready == word taken)
//   grant         registered one-hot burst owner, zero when idle
//   fifo_counter  FIFO occupancy
//   wr_en         registered FIFO write enable
//   buf_in        registered FIFO write data
//   busy          high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic [CNT_W-1:0]          fifo_counter,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         buf_in,
  output logic                      busy
);

  localparam int PTR_W  = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W:0]      DEPTH     = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0]    LAST_REQ  = PTR_W'(NUM_REQ - 1);

  // Two-bit encoding leaves spare codes; those fall into the IDLE branch.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01
  } state_e;

  state_e              state_q,  state_d;
  logic [NUM_REQ-1:0]  grant_q,  grant_d;
  logic                wr_en_q,  wr_en_d;
  logic [DATA_W-1:0]   buf_in_q, buf_in_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q,  owner_d;
  logic [BEAT_W-1:0]   beat_q,   beat_d;

  // Occupancy plus the write already registered but not yet seen by the FIFO.
  // Concurrent reads are ignored, so this never over-reports free space.
  logic [CNT_W:0] occupancy;
  logic           space;

  assign occupancy = {1'b0, fifo_counter} + {{CNT_W{1'b0}}, wr_en_q};
  assign space     = (occupancy < DEPTH);

  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;

  assign owner_valid = req_valid[owner_q];
  assign owner_data  = req_data[owner_q*DATA_W +: DATA_W];

  // Round-robin pick: first valid index at or after rr_ptr, wrapping upward.
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;

  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  // Next-state and outputs.
  always_comb begin
    logic burst_end;
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    grant_d   = grant_q;
    wr_en_d   = 1'b0;
    buf_in_d  = buf_in_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    beat_d    = beat_q;
    req_ready = '0;
    burst_end = 1'b0;

    case (state_q)
      BURST: begin
        // grant_q is the owner's one-hot while bursting.
        req_ready = grant_q & {NUM_REQ{space}};
        if (owner_valid && space) begin
          wr_en_d  = 1'b1;
          buf_in_d = owner_data;
          beat_d   = beat_q + 1'b1;
          burst_end = (beat_q == LAST_BEAT);
        end else if (!owner_valid) begin
          // Owner went away: release so the others are not starved.
          burst_end = 1'b1;
        end
        // valid && !space is a stall: hold the grant and the beat count.

        if (burst_end) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
        end
      end

      default: begin
        // IDLE, and the recovery path for any unused encoding.
        state_d = IDLE;
        grant_d = '0;
        if (pick_found) begin
          state_d  = BURST;
          owner_d  = pick_idx;
          grant_d  = NUM_REQ'(1) << pick_idx;
          beat_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      wr_en_q  <= 1'b0;
      buf_in_q <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wr_en_q  <= wr_en_d;
      buf_in_q <= buf_in_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

  assign grant  = grant_q;
  assign wr_en  = wr_en_q;
  assign buf_in = buf_in_q;
  assign busy   = (state_q == BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the 64-entry byte FIFO among NUM_REQ producers. It grants the FIFO write port to one requester at a time for bursts of up to MAX_BURST words, applies backpressure from the FIFO occupancy count, and drives the FIFO's wr_en/buf_in from registers. It sits directly in front of the FIFO write port. The FIFO's read side is untouched.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: word width; must equal the FIFO data width.
- MAX_BURST, 8: maximum words per grant, 1..16.
- FIFO_DEPTH, 64: FIFO capacity in words.
- CNT_W, 7: width of the FIFO occupancy count.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word-available flag.
- req_data  in  NUM_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  combinational; word accepted this cycle when req_valid[i] && req_ready[i].
- grant  out  NUM_REQ  registered one-hot burst owner; all zero when idle.
- fifo_counter  in  CNT_W  FIFO occupancy.
- wr_en  out  1  registered FIFO write enable.
- buf_in  out  DATA_W  registered FIFO write data.
- busy  out  1  high while in BURST.

## Operation
- Reset values: state=IDLE, grant=0, wr_en=0, buf_in=0, busy=0, rr_ptr=0, owner=0, beat_cnt=0. req_ready is 0 because state is IDLE.
- space = ({1'b0,fifo_counter} + wr_en) < FIFO_DEPTH, evaluated at CNT_W+1 bits.
  - The wr_en term covers the write already in flight that the FIFO has not yet counted.
  - Concurrent FIFO reads are ignored, so space is conservative.
  - Overflow is impossible by construction.
- IDLE:
  - req_ready = 0.
  - If any req_valid is high, pick the first set index at or after rr_ptr, scanning upward with wrap.
  - Set owner to that index, set grant to its one-hot, set beat_cnt=0, and go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - req_ready[owner] = space. All other req_ready bits are 0.
  - Accept (req_valid[owner] && space): next wr_en=1, buf_in=req_data[owner], beat_cnt+1.
  - Otherwise next wr_en=0 and buf_in holds its value.
  - Exit to IDLE when either:
    - an accept occurs with beat_cnt==MAX_BURST-1, or
    - req_valid[owner] is 0 in any BURST cycle (word not taken).
  - On exit: grant=0 and rr_ptr = (owner+1) mod NUM_REQ.
  - space=0 with req_valid[owner]=1 is a stall: stay in BURST and keep beat_cnt.
- Widths:
  - beat_cnt is clog2(MAX_BURST+1) bits.
  - rr_ptr and owner are clog2(NUM_REQ) bits, at least 1.
  - rr_ptr wraps NUM_REQ-1 → 0.
- Any other state value decodes to IDLE.

## Timing
- Arbitration latency:
  - 1 cycle from req_valid rising in IDLE to grant/busy high.
  - The first accept can occur in the first BURST cycle.
- wr_en/buf_in appear 1 cycle after the accepting edge, and the FIFO writes them on the following edge.
- Back-to-back bursts:
  - Each burst end costs exactly 1 IDLE cycle.
  - Peak sustained throughput is MAX_BURST/(MAX_BURST+1) words/cycle.
- A requester dropping req_valid mid-burst loses its grant. It rejoins arbitration last, behind the others.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0 with no requester skipped.
- Reset asserted mid-burst:
  - All registers return to their reset values immediately (asynchronous).
  - A pending wr_en is dropped; that word is lost and is the requester's responsibility.
  - The first grant after reset release goes to the lowest valid index.

## Test plan
- Single requester: req_valid[2]=1 with data 0x10..0x1F, fifo_counter=0.
  - grant=4'b0100 one cycle later.
  - 8 accepts write 0x10..0x17 on consecutive wr_en cycles.
  - Then 1 IDLE cycle and a new 8-word burst starting 0x18.
- Round robin: all 4 requesters continuously valid, MAX_BURST=8.
  - grant sequence 0001,0010,0100,1000,0001.
  - Each burst is exactly 8 wr_en pulses, separated by 1-cycle gaps.
- Full backpressure: fifo_counter=63, wr_en=0, owner valid.
  - One accept occurs; next cycle space=0 (63+1), so req_ready=0 and wr_en stays low.
  - Force fifo_counter=62: accepts resume.
  - No write ever occurs while fifo_counter=64.
- Early termination: requester 1 drops req_valid after 3 accepts.
  - Burst ends with 3 writes and grant=0.
  - Next grant goes to requester 2 if valid; requester 1 is served only after requesters 2, 3 and 0.
- Reset mid-burst: assert rst after 5 accepts.
  - wr_en, grant, busy and buf_in are 0 in the same cycle.
  - After release with req_valid=4'b1010, grant=4'b0010.
- Stall inside burst: owner valid, space toggles 1,0,0,1.
  - beat_cnt holds during the stall.
  - Total accepts still equal MAX_BURST before the grant is released.
